// File: rtl/program_counter_ras.sv
// Program counter with a circular return-address stack (SEQ/JUMP/BREL/CALL/RET).
// Define PC_RAS_TRACE_EN to compile a simulation-only per-edge trace printout.
module program_counter_ras #(
    parameter int WIDTH     = 16,
    parameter int STEP      = 1,
    parameter int RESET_VEC = 0,
    parameter int DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_SEQ  = 3'b000,
        OP_JUMP = 3'b001,
        OP_BREL = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100
    } op_t;

    logic [WIDTH-1:0] stack [DEPTH];
    logic [PW-1:0]    ptr, ptr_next, ptr_inc, ptr_dec;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] pc_next, pc_seq, pop_val;
    logic             push, ovf_next, unf_next;

    assign pc_seq  = pc + WIDTH'(STEP);
    assign ptr_inc = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    assign ptr_dec = (ptr == '0) ? PW'(DEPTH - 1) : ptr - 1'b1;
    assign pop_val = stack[ptr_dec];

    // When full, the pointer already sits on the oldest entry, so a push overwrites it.
    always_comb begin
        pc_next    = pc;
        ptr_next   = ptr;
        count_next = count;
        push       = 1'b0;
        ovf_next   = ras_overflow;
        unf_next   = ras_underflow;
        if (!stall) begin
            case (op)
                OP_JUMP: pc_next = target;
                OP_BREL: pc_next = pc + target;
                OP_CALL: begin
                    pc_next  = target;
                    push     = 1'b1;
                    ptr_next = ptr_inc;
                    if (count == CW'(DEPTH)) ovf_next = 1'b1;
                    else                     count_next = count + 1'b1;
                end
                OP_RET: begin
                    if (count == '0) begin
                        pc_next  = pc_seq;
                        unf_next = 1'b1;
                    end else begin
                        pc_next    = pop_val;
                        ptr_next   = ptr_dec;
                        count_next = count - 1'b1;
                    end
                end
                default: pc_next = pc_seq;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= WIDTH'(RESET_VEC);
            ptr           <= '0;
            count         <= '0;
            ras_empty     <= 1'b1;
            ras_full      <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_next;
            ptr           <= ptr_next;
            count         <= count_next;
            ras_empty     <= (count_next == '0);
            ras_full      <= (count_next == CW'(DEPTH));
            ras_overflow  <= ovf_next;
            ras_underflow <= unf_next;
        end
    end

    // Stack storage needs no reset; entries are only read below the live count.
    always_ff @(posedge clk) begin
        if (rst_n && push) stack[ptr] <= pc_seq;
    end

`ifdef PC_RAS_TRACE_EN
    always @(posedge clk) begin
        if (rst_n && !stall) begin
            $display("[RAS] pc=%h op=%0d target=%h next=%h count=%0d push=%h pop=%h",
                     pc, op, target, pc_next, count_next, pc_seq, pop_val);
            if (op == OP_CALL && count == CW'(DEPTH))
                $display("[RAS] warning: overflow, oldest return address dropped");
            if (op == OP_RET && count == '0)
                $display("[RAS] warning: underflow, return with empty stack");
        end
    end
`endif

endmodule

// File: tb/tb_program_counter_ras.sv
// Scoreboard bench for program_counter_ras: directed vectors queue expected state,
// a monitor pops and compares after each clock edge.
module tb_program_counter_ras;

    localparam int WIDTH = 16;

    localparam logic [2:0] SEQ  = 3'b000;
    localparam logic [2:0] JUMP = 3'b001;
    localparam logic [2:0] BREL = 3'b010;
    localparam logic [2:0] CALL = 3'b011;
    localparam logic [2:0] RET  = 3'b100;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] pc;
        logic             empty;
        logic             full;
        logic             ovf;
        logic             unf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic [2:0]       op;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc;
    logic             ras_empty, ras_full, ras_overflow, ras_underflow;

    exp_t exp_q [$];
    int   vectors;
    int   miscompares;

    program_counter_ras #(.WIDTH(WIDTH), .STEP(1), .RESET_VEC(0), .DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .op           (op),
        .target       (target),
        .pc           (pc),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input exp_t e);
        vectors++;
        if (pc !== e.pc || ras_empty !== e.empty || ras_full !== e.full ||
            ras_overflow !== e.ovf || ras_underflow !== e.unf) begin
            miscompares++;
            $display("[TB] FAIL %s: got pc=%h e=%b f=%b ovf=%b unf=%b, want pc=%h e=%b f=%b ovf=%b unf=%b",
                     e.name, pc, ras_empty, ras_full, ras_overflow, ras_underflow,
                     e.pc, e.empty, e.full, e.ovf, e.unf);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the state expected after the next rising edge.
    task automatic apply_stimulus(input string name, input logic s, input logic [2:0] o,
                                  input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] epc,
                                  input logic ee, input logic ef, input logic eo, input logic eu);
        exp_t e;
        @(negedge clk);
        rst_n  = 1'b1;
        stall  = s;
        op     = o;
        target = t;
        e.name = name; e.pc = epc; e.empty = ee; e.full = ef; e.ovf = eo; e.unf = eu;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string name, input logic [WIDTH-1:0] epc,
                                input logic ee, input logic ef, input logic eo, input logic eu);
        exp_t e;
        e.name = name; e.pc = epc; e.empty = ee; e.full = ef; e.ovf = eo; e.unf = eu;
        compare(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) compare(exp_q.pop_front());
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        stall  = 1'b1;
        op     = SEQ;
        target = '0;
        repeat (3) @(posedge clk);
        #2;
        check_output("reset_state", 16'h0000, 1, 0, 0, 0);

        apply_stimulus("seq1", 0, SEQ, 16'h0000, 16'h0001, 1, 0, 0, 0);
        apply_stimulus("seq2", 0, SEQ, 16'h0000, 16'h0002, 1, 0, 0, 0);
        apply_stimulus("seq3", 0, SEQ, 16'h0000, 16'h0003, 1, 0, 0, 0);

        apply_stimulus("jump_ffff", 0, JUMP, 16'hFFFF, 16'hFFFF, 1, 0, 0, 0);
        apply_stimulus("seq_wrap",  0, SEQ,  16'h0000, 16'h0000, 1, 0, 0, 0);
        apply_stimulus("jump_0010", 0, JUMP, 16'h0010, 16'h0010, 1, 0, 0, 0);
        apply_stimulus("brel_neg2", 0, BREL, 16'hFFFE, 16'h000E, 1, 0, 0, 0);

        apply_stimulus("jump_0010b", 0, JUMP, 16'h0010, 16'h0010, 1, 0, 0, 0);
        apply_stimulus("call_0100",  0, CALL, 16'h0100, 16'h0100, 0, 0, 0, 0);
        apply_stimulus("call_0200",  0, CALL, 16'h0200, 16'h0200, 0, 0, 0, 0);
        apply_stimulus("ret_0101",   0, RET,  16'h0000, 16'h0101, 0, 0, 0, 0);
        apply_stimulus("ret_0011",   0, RET,  16'h0000, 16'h0011, 1, 0, 0, 0);

        apply_stimulus("jump_0000", 0, JUMP, 16'h0000, 16'h0000, 1, 0, 0, 0);
        apply_stimulus("call_10",   0, CALL, 16'h0010, 16'h0010, 0, 0, 0, 0);
        apply_stimulus("call_20",   0, CALL, 16'h0020, 16'h0020, 0, 0, 0, 0);
        apply_stimulus("call_30",   0, CALL, 16'h0030, 16'h0030, 0, 0, 0, 0);
        apply_stimulus("call_40",   0, CALL, 16'h0040, 16'h0040, 0, 1, 0, 0);
        apply_stimulus("call_50",   0, CALL, 16'h0050, 16'h0050, 0, 1, 1, 0);
        apply_stimulus("ret_41",    0, RET,  16'h0000, 16'h0041, 0, 0, 1, 0);
        apply_stimulus("ret_31",    0, RET,  16'h0000, 16'h0031, 0, 0, 1, 0);
        apply_stimulus("ret_21",    0, RET,  16'h0000, 16'h0021, 0, 0, 1, 0);
        apply_stimulus("ret_11",    0, RET,  16'h0000, 16'h0011, 1, 0, 1, 0);

        apply_stimulus("jump_0005",  0, JUMP, 16'h0005, 16'h0005, 1, 0, 1, 0);
        apply_stimulus("ret_empty",  0, RET,  16'h0000, 16'h0006, 1, 0, 1, 1);
        apply_stimulus("seq_sticky", 0, SEQ,  16'h0000, 16'h0007, 1, 0, 1, 1);
        apply_stimulus("stall1",     1, CALL, 16'h0100, 16'h0007, 1, 0, 1, 1);
        apply_stimulus("stall2",     1, CALL, 16'h0100, 16'h0007, 1, 0, 1, 1);
        apply_stimulus("stall3",     1, CALL, 16'h0100, 16'h0007, 1, 0, 1, 1);
        apply_stimulus("call_after_stall", 0, CALL, 16'h0100, 16'h0100, 0, 0, 1, 1);
        apply_stimulus("call_0200b",       0, CALL, 16'h0200, 16'h0200, 0, 0, 1, 1);

        // Assert reset between edges, after the monitor has consumed the last vector.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("async_reset", 16'h0000, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        check_output("reset_held", 16'h0000, 1, 0, 0, 0);

        apply_stimulus("seq_after_reset", 0, SEQ, 16'h0000, 16'h0001, 1, 0, 0, 0);
        apply_stimulus("ret_after_reset", 0, RET, 16'h0000, 16'h0002, 1, 0, 0, 1);
        apply_stimulus("stall_tail",      1, SEQ, 16'h0000, 16'h0002, 1, 0, 0, 1);

        repeat (5) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
